// File: rtl/regarb_pkg.sv
// Shared types and default sizes for the register-file access arbiter.
package regarb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_DATA_W  = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after last_grant, wrapping.
module rr_arbiter
  import regarb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Offsets 1..NUM_REQ visit every requester once, ending on last_grant itself.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!any && req[cand]) begin
        any   = 1'b1;
        grant = cand;
      end
    end
  end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing a single-port register file between NUM_REQ clients.
// Build option: define REGARB_ZERO_REG_EN to make address 0 a hardwired zero register.
module regfile_access_arbiter
  import regarb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rf_read_en,
  output logic                      rf_write_en,
  output logic [ADDR_W-1:0]         rf_addr,
  output logic [DATA_W-1:0]         rf_write_data,
  input  logic [DATA_W-1:0]         rf_read_data
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

`ifdef REGARB_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  state_t             state;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   last_grant;
  logic               cmd_we;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [DATA_W-1:0]  cmd_wdata;

  logic [IDX_W-1:0]   pick;
  logic               pick_any;
  logic               win_we;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;
  logic               win_zero;
  logic               cmd_zero;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick),
    .any        (pick_any)
  );

  always_comb begin
    win_we    = req_we[pick];
    win_addr  = req_addr[int'(pick)*ADDR_W +: ADDR_W];
    win_wdata = req_wdata[int'(pick)*DATA_W +: DATA_W];
    win_zero  = ZERO_REG && (win_addr == '0);
    cmd_zero  = ZERO_REG && (cmd_addr == '0);
  end

  // Outputs are registered one state ahead so each pulse lines up with the state it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      grant         <= '0;
      last_grant    <= IDX_W'(NUM_REQ - 1);
      cmd_we        <= 1'b0;
      cmd_addr      <= '0;
      cmd_wdata     <= '0;
      rsp_rdata     <= '0;
      req_ready     <= '0;
      rsp_valid     <= '0;
      rf_read_en    <= 1'b0;
      rf_write_en   <= 1'b0;
      rf_addr       <= '0;
      rf_write_data <= '0;
    end else begin
      req_ready     <= '0;
      rsp_valid     <= '0;
      rf_read_en    <= 1'b0;
      rf_write_en   <= 1'b0;
      rf_addr       <= '0;
      rf_write_data <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant         <= pick;
            last_grant    <= pick;
            cmd_we        <= win_we;
            cmd_addr      <= win_addr;
            cmd_wdata     <= win_wdata;
            req_ready     <= ONE << pick;
            rf_addr       <= win_addr;
            rf_write_en   <= win_we && !win_zero;
            rf_read_en    <= !win_we && !win_zero;
            rf_write_data <= (win_we && !win_zero) ? win_wdata : '0;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          if (cmd_we) begin
            rsp_valid <= ONE << grant;
            state     <= RESP;
          end else begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          rsp_rdata <= cmd_zero ? '0 : rf_read_data;
          rsp_valid <= ONE << grant;
          state     <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Latched write data is kept with the command; only its parity is folded into nothing observable.
  logic unused_ok;
  assign unused_ok = ^cmd_wdata;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Randomized self-checking bench for regfile_access_arbiter with a transaction-level model.
// Honours REGARB_ZERO_REG_EN the same way the design does.
module tb_regfile_access_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;

`ifdef REGARB_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_we = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rf_read_en;
  logic                      rf_write_en;
  logic [ADDR_W-1:0]         rf_addr;
  logic [DATA_W-1:0]         rf_write_data;
  logic [DATA_W-1:0]         rf_read_data;

  regfile_access_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rf_read_en    (rf_read_en),
    .rf_write_en   (rf_write_en),
    .rf_addr       (rf_addr),
    .rf_write_data (rf_write_data),
    .rf_read_data  (rf_read_data)
  );

  always #5 clk = ~clk;

  // Register file behind the arbiter: registered read, write on enable.
  logic [DATA_W-1:0] rf_mem [16];
  int zero_writes = 0;
  always @(posedge clk) begin
    if (rf_write_en) rf_mem[rf_addr] <= rf_write_data;
    if (rf_read_en) rf_read_data <= rf_mem[rf_addr];
    if (rf_write_en && rf_addr == '0) zero_writes++;
  end

  int errors = 0;
  int checks = 0;

  int                 m_last = NUM_REQ - 1;
  logic [DATA_W-1:0]  exp_mem [16];
  logic [DATA_W-1:0]  exp_rdata = '0;
  logic [NUM_REQ-1:0] seen_ready;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic setReq(input int i, input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  // Runs one whole transaction from an idle DUT, starting and ending on a falling edge.
  task automatic applyStimulus();
    int w;
    logic we;
    logic zero;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [NUM_REQ-1:0] oh;
    if (req_valid == '0) begin
      @(negedge clk);
      checkOutput("idle_ready", req_ready, 0);
      return;
    end
    w = -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (m_last + k) % NUM_REQ;
      if (w < 0 && req_valid[c]) w = c;
    end
    we = req_we[w];
    a = req_addr[w*ADDR_W +: ADDR_W];
    d = req_wdata[w*DATA_W +: DATA_W];
    oh = '0;
    oh[w] = 1'b1;
    zero = ZERO_EN && (a == '0);

    @(negedge clk);
    seen_ready = req_ready;
    checkOutput("ready", req_ready, oh);
    checkOutput("rsp_early", rsp_valid, 0);
    checkOutput("rf_addr", rf_addr, a);
    checkOutput("rf_write_en", rf_write_en, we && !zero);
    checkOutput("rf_read_en", rf_read_en, !we && !zero);
    checkOutput("rf_write_data", rf_write_data, (we && !zero) ? d : 0);

    // The winner drops its request and scribbles its fields; the latched command must be unaffected.
    req_valid[w] = 1'b0;
    req_we[w] = 1'($urandom_range(0, 1));
    req_addr[w*ADDR_W +: ADDR_W] = a ^ 4'hC;
    req_wdata[w*DATA_W +: DATA_W] = $urandom;
    m_last = w;

    if (we) begin
      if (!zero) exp_mem[a] = d;
      @(negedge clk);
      checkOutput("wr_rsp", rsp_valid, oh);
      checkOutput("wr_ready_once", req_ready, 0);
      checkOutput("wr_en_off", rf_write_en, 0);
      checkOutput("rdata_hold", rsp_rdata, exp_rdata);
    end else begin
      exp_rdata = zero ? '0 : exp_mem[a];
      @(negedge clk);
      checkOutput("rd_wait_rsp", rsp_valid, 0);
      checkOutput("rd_en_off", rf_read_en, 0);
      checkOutput("rd_wdata_zero", rf_write_data, 0);
      @(negedge clk);
      checkOutput("rd_rsp", rsp_valid, oh);
      checkOutput("rd_data", rsp_rdata, exp_rdata);
    end
    @(negedge clk);
    checkOutput("rsp_one_cycle", rsp_valid, 0);
  endtask

  initial begin
    logic [ADDR_W-1:0] ra;
    #1;
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_rsp", rsp_valid, 0);
    checkOutput("rst_rdata", rsp_rdata, 0);
    checkOutput("rst_rf_en", {rf_read_en, rf_write_en}, 0);
    checkOutput("rst_rf_addr", rf_addr, 0);
    checkOutput("rst_rf_wdata", rf_write_data, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      setReq(0, 1'b1, 4'(i), $urandom);
      applyStimulus();
    end

    $display("[TB] reset during ACCESS");
    setReq(0, 1'b1, 4'd7, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("abort_ready", req_ready, 1);
    rst = 1'b0;
    req_valid = '0;
    #1;
    checkOutput("abort_ready_clr", req_ready, 0);
    checkOutput("abort_we_clr", rf_write_en, 0);
    checkOutput("abort_addr_clr", rf_addr, 0);
    checkOutput("abort_wdata_clr", rf_write_data, 0);
    checkOutput("abort_rdata_clr", rsp_rdata, 0);
    m_last = NUM_REQ - 1;
    exp_rdata = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort_no_rsp", rsp_valid, 0);
      checkOutput("abort_no_ready", req_ready, 0);
    end

    $display("[TB] round-robin with both requesters reading");
    for (int r = 0; r < 4; r++) begin
      if (!req_valid[0]) setReq(0, 1'b0, 4'd1, '0);
      if (!req_valid[1]) setReq(1, 1'b0, 4'd2, '0);
      applyStimulus();
      checkOutput("rr_alternate", seen_ready, NUM_REQ'(1) << (r % 2));
    end
    req_valid = '0;

    setReq(0, 1'b0, 4'd7, '0);
    applyStimulus();

    $display("[TB] write then read addr 3");
    setReq(0, 1'b1, 4'd3, 32'h43211234);
    applyStimulus();
    setReq(0, 1'b0, 4'd3, '0);
    applyStimulus();
    checkOutput("wr_rd_addr3", rsp_rdata, 32'h43211234);

    setReq(1, 1'b0, 4'd5, '0);
    applyStimulus();

    $display("[TB] address 0 write/read");
    setReq(0, 1'b1, 4'd0, 32'hFFFFFFFF);
    applyStimulus();
    setReq(0, 1'b0, 4'd0, '0);
    applyStimulus();
    checkOutput("addr0_read", rsp_rdata, ZERO_EN ? 32'h0 : 32'hFFFFFFFF);

    setReq(1, 1'b1, 4'd15, $urandom);
    applyStimulus();
    setReq(1, 1'b1, 4'd0, $urandom);
    applyStimulus();

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 5))
            0: ra = 4'd0;
            1: ra = 4'd15;
            default: ra = 4'($urandom_range(0, 15));
          endcase
          setReq(i, 1'($urandom_range(0, 1)), ra, $urandom);
        end
      end
      applyStimulus();
    end

    if (ZERO_EN) checkOutput("zero_reg_never_written", zero_writes, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
